memory_access_arbiter: RTL and testbench

//  Shares the single memory interface between the multicycle core's instruction-fetch

---
 rtl/memory_access_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_access_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto one memory port,
// one transaction at a time, with round-robin tie-breaking and a fixed read latency.
module memory_access_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic              oIAck,
  output logic [DATA_W-1:0] oIRData,
  input  logic              iDReq,
  input  logic              iDWe,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic              oDAck,
  output logic [DATA_W-1:0] oDRData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oBusy
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t             r_state;
  state_t             w_next;
  owner_t             r_owner;
  owner_t             r_last_grant;
  owner_t             w_grant;
  logic               w_grant_valid;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [2:0]         r_cnt;
  logic [DATA_W-1:0]  r_irdata;
  logic [DATA_W-1:0]  r_drdata;

  // On a tie the side that did not win last time gets the bus.
  always_comb begin
    w_grant_valid = iIReq | iDReq;
    w_grant       = OWN_I;
    if (iIReq && iDReq) begin
      w_grant = (r_last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (iDReq) begin
      w_grant = OWN_D;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_valid) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:   if (r_cnt == 3'd1) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_owner      <= OWN_I;
      r_last_grant <= OWN_D;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_irdata     <= '0;
      r_drdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            if (w_grant == OWN_I) begin
              r_addr  <= iIAddr;
              r_we    <= 1'b0;
              r_wdata <= '0;
            end else begin
              r_addr  <= iDAddr;
              r_we    <= iDWe;
              r_wdata <= iDWData;
            end
          end
        end
        S_ACCESS: begin
          if (!r_we) r_cnt <= LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          // Only the owner's return register is written; the other side keeps its word.
          if (r_cnt == 3'd1) begin
            if (r_owner == OWN_I) r_irdata <= iMemRData;
            else                  r_drdata <= iMemRData;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and acks decode the state directly so reset drops them without waiting for an edge.
  always_comb begin
    oMemRead  = (r_state == S_ACCESS) && !r_we;
    oMemWrite = (r_state == S_ACCESS) &&  r_we;
    oIAck     = (r_state == S_RESP) && (r_owner == OWN_I);
    oDAck     = (r_state == S_RESP) && (r_owner == OWN_D);
    oBusy     = (r_state != S_IDLE);
    oMemAddr  = r_addr;
    oMemWData = r_wdata;
    oIRData   = r_irdata;
    oDRData   = r_drdata;
  end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench: one arbiter at READ_LATENCY=1 for most scenarios, a second at 3 for the latency case.
module tb_memory_access_arbiter;

  logic        clk;
  logic        rst_n;

  logic        iIReq;
  logic [31:0] iIAddr;
  logic        oIAck;
  logic [31:0] oIRData;
  logic        iDReq;
  logic        iDWe;
  logic [31:0] iDAddr;
  logic [31:0] iDWData;
  logic        oDAck;
  logic [31:0] oDRData;
  logic [31:0] oMemAddr;
  logic        oMemRead;
  logic        oMemWrite;
  logic [31:0] oMemWData;
  logic [31:0] iMemRData;
  logic        oBusy;

  logic        iIReq3;
  logic [31:0] iIAddr3;
  logic        oIAck3;
  logic [31:0] oIRData3;
  logic        iDReq3;
  logic        iDWe3;
  logic [31:0] iDAddr3;
  logic [31:0] iDWData3;
  logic        oDAck3;
  logic [31:0] oDRData3;
  logic [31:0] oMemAddr3;
  logic        oMemRead3;
  logic        oMemWrite3;
  logic [31:0] oMemWData3;
  logic [31:0] iMemRData3;
  logic        oBusy3;

  int tests_run    = 0;
  int tests_failed = 0;

  memory_access_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iIReq(iIReq), .iIAddr(iIAddr), .oIAck(oIAck), .oIRData(oIRData),
    .iDReq(iDReq), .iDWe(iDWe), .iDAddr(iDAddr), .iDWData(iDWData),
    .oDAck(oDAck), .oDRData(oDRData),
    .oMemAddr(oMemAddr), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oMemWData(oMemWData), .iMemRData(iMemRData), .oBusy(oBusy)
  );

  memory_access_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .iCLK(clk), .iRST_N(rst_n),
    .iIReq(iIReq3), .iIAddr(iIAddr3), .oIAck(oIAck3), .oIRData(oIRData3),
    .iDReq(iDReq3), .iDWe(iDWe3), .iDAddr(iDAddr3), .iDWData(iDWData3),
    .oDAck(oDAck3), .oDRData(oDRData3),
    .oMemAddr(oMemAddr3), .oMemRead(oMemRead3), .oMemWrite(oMemWrite3),
    .oMemWData(oMemWData3), .iMemRData(iMemRData3), .oBusy(oBusy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_3093;
    return a ^ 32'hC3C3_5A5A;
  endfunction

  // Memory model: data is valid only in the cycle exactly L edges after the strobe was sampled.
  int mcnt  = 0;
  int mcnt3 = 0;
  always @(posedge clk) begin
    if (oMemRead) mcnt <= 1;
    else if (mcnt != 0 && mcnt < 8) mcnt <= mcnt + 1;
    if (oMemRead3) mcnt3 <= 1;
    else if (mcnt3 != 0 && mcnt3 < 8) mcnt3 <= mcnt3 + 1;
  end
  assign iMemRData  = (mcnt  == 1) ? memword(oMemAddr)  : 32'hBAD0_BAD0;
  assign iMemRData3 = (mcnt3 == 3) ? memword(oMemAddr3) : 32'hBAD3_BAD3;

  task automatic do_reset();
    rst_n = 1'b0;
    iIReq = 1'b0; iIAddr = '0; iDReq = 1'b0; iDWe = 1'b0; iDAddr = '0; iDWData = '0;
    iIReq3 = 1'b0; iIAddr3 = '0; iDReq3 = 1'b0; iDWe3 = 1'b0; iDAddr3 = '0; iDWData3 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iIReq = 1'b0; iIAddr = '0; iDReq = 1'b0; iDWe = 1'b0; iDAddr = '0; iDWData = '0;
    iIReq3 = 1'b0; iIAddr3 = '0; iDReq3 = 1'b0; iDWe3 = 1'b0; iDAddr3 = '0; iDWData3 = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({oIAck, oDAck, oBusy, oMemRead, oMemWrite} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 00000", {oIAck, oDAck, oBusy, oMemRead, oMemWrite});
    end
    tests_run++;
    if ({oMemAddr, oMemWData, oIRData, oDRData} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h ir=%h dr=%h expected all 0",
               oMemAddr, oMemWData, oIRData, oDRData);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    int rd_cnt = 0, ack_cnt = 0, ack_at = -1, busy_bad = 0, dack_cnt = 0;
    logic [31:0] addr_seen = '0;
    iIReq = 1'b1; iIAddr = 32'h0000_0010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (oMemRead) begin rd_cnt++; if (k == 1) addr_seen = oMemAddr; end
      if (oIAck) begin ack_cnt++; ack_at = k; iIReq = 1'b0; end
      if (oDAck) dack_cnt++;
      if (oBusy !== (k <= 3)) busy_bad++;
    end
    tests_run++;
    if (rd_cnt != 1 || addr_seen !== 32'h0000_0010) begin
      tests_failed++;
      $display("FAIL i_read_strobe: reads=%0d addr=%h expected 1 read at 00000010", rd_cnt, addr_seen);
    end
    tests_run++;
    if (ack_cnt != 1 || ack_at != 3 || dack_cnt != 0) begin
      tests_failed++;
      $display("FAIL i_read_ack: acks=%0d at=%0d dacks=%0d expected 1 at 3, 0 dacks", ack_cnt, ack_at, dack_cnt);
    end
    tests_run++;
    if (oIRData !== 32'h0051_3093) begin
      tests_failed++;
      $display("FAIL i_read_data: got %h expected 00513093", oIRData);
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("FAIL i_read_busy: %0d bad cycles expected 0", busy_bad);
    end
  endtask

  task automatic test_d_write();
    int wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, ack_at = -1;
    logic [31:0] a_seen = '0, d_seen = '0;
    iDReq = 1'b1; iDWe = 1'b1; iDAddr = 32'h1000_0004; iDWData = 32'hDEAD_BEEF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (oMemWrite) begin wr_cnt++; a_seen = oMemAddr; d_seen = oMemWData; end
      if (oMemRead) rd_cnt++;
      if (oDAck) begin ack_cnt++; ack_at = k; iDReq = 1'b0; end
    end
    tests_run++;
    if (wr_cnt != 1 || a_seen !== 32'h1000_0004 || d_seen !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL d_write_strobe: writes=%0d addr=%h data=%h expected 1 10000004 deadbeef",
               wr_cnt, a_seen, d_seen);
    end
    tests_run++;
    if (ack_cnt != 1 || ack_at != 2 || rd_cnt != 0) begin
      tests_failed++;
      $display("FAIL d_write_ack: acks=%0d at=%0d reads=%0d expected 1 at 2, 0 reads", ack_cnt, ack_at, rd_cnt);
    end
    iDWe = 1'b0;
  endtask

  task automatic test_round_robin();
    int n = 0, both = 0;
    logic [3:0] order = '0;
    int at [4];
    do_reset();
    iIReq = 1'b1; iIAddr = 32'h0000_0010;
    iDReq = 1'b1; iDWe = 1'b0; iDAddr = 32'h1000_0000;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      if (oIAck && oDAck) both++;
      if (oIAck || oDAck) begin
        order[n] = oDAck;
        at[n] = k;
        n++;
      end
    end
    iIReq = 1'b0; iDReq = 1'b0;
    tests_run++;
    if (n != 4 || order !== 4'b1010 || both != 0) begin
      tests_failed++;
      $display("FAIL rr_order: grants=%0d order(bit0 first, 1=D)=%b both=%0d expected 4 1010 0", n, order, both);
    end
    tests_run++;
    if (n != 4 || at[0] != 3 || at[1] != 7 || at[2] != 11 || at[3] != 15) begin
      tests_failed++;
      $display("FAIL rr_spacing: ack cycles %0d %0d %0d %0d expected 3 7 11 15", at[0], at[1], at[2], at[3]);
    end
    tests_run++;
    if (oIRData !== 32'h0051_3093 || oDRData !== memword(32'h1000_0000)) begin
      tests_failed++;
      $display("FAIL rr_data: ir=%h dr=%h expected 00513093 %h", oIRData, oDRData, memword(32'h1000_0000));
    end
    @(negedge clk);
  endtask

  task automatic test_d_read_lat3();
    int rd_cnt = 0, ack_cnt = 0, ack_at = -1;
    iDReq3 = 1'b1; iDWe3 = 1'b0; iDAddr3 = 32'h1000_0008;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (oMemRead3) rd_cnt++;
      if (oDAck3) begin ack_cnt++; ack_at = k; iDReq3 = 1'b0; end
    end
    tests_run++;
    if (rd_cnt != 1 || ack_cnt != 1 || ack_at != 5) begin
      tests_failed++;
      $display("FAIL lat3_ack: reads=%0d acks=%0d at=%0d expected 1 1 at 5", rd_cnt, ack_cnt, ack_at);
    end
    tests_run++;
    if (oDRData3 !== (32'h1000_0008 ^ 32'hC3C3_5A5A)) begin
      tests_failed++;
      $display("FAIL lat3_data: got %h expected %h", oDRData3, 32'h1000_0008 ^ 32'hC3C3_5A5A);
    end
  endtask

  task automatic test_drop_req();
    int rd_cnt = 0, ack_cnt = 0;
    iDReq = 1'b1; iDWe = 1'b0; iDAddr = 32'h1000_0020;
    @(negedge clk);
    iDReq = 1'b0; iDAddr = 32'h1000_0040;
    if (oMemRead) rd_cnt++;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (oMemRead) rd_cnt++;
      if (oDAck) ack_cnt++;
    end
    tests_run++;
    if (ack_cnt != 1 || rd_cnt != 1) begin
      tests_failed++;
      $display("FAIL drop_ack: acks=%0d reads=%0d expected 1 1", ack_cnt, rd_cnt);
    end
    tests_run++;
    if (oBusy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_busy: got %b expected 0", oBusy);
    end
    tests_run++;
    if (oDRData !== (32'h1000_0020 ^ 32'hC3C3_5A5A) || oIRData !== 32'h0051_3093) begin
      tests_failed++;
      $display("FAIL drop_data: dr=%h ir=%h expected %h 00513093",
               oDRData, oIRData, 32'h1000_0020 ^ 32'hC3C3_5A5A);
    end
  endtask

  task automatic test_reset_wait();
    int ack_cnt = 0, ack_at = -1;
    iIReq = 1'b1; iIAddr = 32'h0000_0020;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (oBusy !== 1'b1 || oMemRead !== 1'b0) begin
      tests_failed++;
      $display("FAIL rw_in_wait: busy=%b read=%b expected 1 0", oBusy, oMemRead);
    end
    rst_n = 1'b0;
    iIReq = 1'b0;
    #1;
    tests_run++;
    if ({oBusy, oMemRead, oMemWrite, oIAck, oDAck} !== 5'b0 || oIRData !== 32'h0) begin
      tests_failed++;
      $display("FAIL rw_async: busy/rd/wr/iack/dack=%b ir=%h expected 00000 0",
               {oBusy, oMemRead, oMemWrite, oIAck, oDAck}, oIRData);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 2) rst_n = 1'b1;
      @(negedge clk);
      if (oIAck || oDAck || oBusy) ack_cnt++;
    end
    tests_run++;
    if (ack_cnt != 0) begin
      tests_failed++;
      $display("FAIL rw_abort: %0d active cycles expected 0", ack_cnt);
    end
    ack_cnt = 0;
    iIReq = 1'b1; iIAddr = 32'h0000_0010;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (oIAck) begin ack_cnt++; ack_at = k; iIReq = 1'b0; end
    end
    tests_run++;
    if (ack_cnt != 1 || ack_at != 3 || oIRData !== 32'h0051_3093) begin
      tests_failed++;
      $display("FAIL rw_recover: acks=%0d at=%0d ir=%h expected 1 at 3 00513093", ack_cnt, ack_at, oIRData);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_d_read_lat3();
    test_drop_req();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
